// File: rtl/modbus_pkg.sv
// Shared Modbus definitions for the RTU slave blocks.
// Holds the address/data widths, the exception code returned for illegal
// register accesses, the write-path FSM state encoding and a small address
// helper used by every block that maps Modbus addresses onto local indices.
package modbus_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    localparam logic [7:0] EXC_ILLEGAL_ADDR = 8'h02;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STAGE  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_COMMIT = 2'd3
    } wr_state_e;

    // Local register index of a Modbus address; wraps modulo 2^16 so
    // addresses below the base land far out of range instead of aliasing.
    function automatic logic [ADDR_W-1:0] addr_offset(
        input logic [ADDR_W-1:0] addr,
        input logic [ADDR_W-1:0] base
    );
        return addr - base;
    endfunction

endpackage

// File: rtl/modbus_holding_reg_bank_if.sv
// Word-serial request bus between the Modbus function handler (master)
// and the holding-register bank (slave).
//   write: wr_req/wr_addr/wr_data/wr_last in, wr_done/wr_status back
//   read : rd_req/rd_addr in, rd_vld/rd_data/rd_err back one cycle later
interface modbus_holding_reg_bank_if;
    import modbus_pkg::*;

    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_last;
    logic              wr_done;
    logic              wr_status;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_vld;
    logic              rd_err;

    modport master (
        output wr_req, wr_addr, wr_data, wr_last, rd_req, rd_addr,
        input  wr_done, wr_status, rd_data, rd_vld, rd_err
    );

    modport slave (
        input  wr_req, wr_addr, wr_data, wr_last, rd_req, rd_addr,
        output wr_done, wr_status, rd_data, rd_vld, rd_err
    );

endinterface

// File: rtl/modbus_irq_stretch.sv
// Reloadable pulse stretcher: a load strobe raises irq_o on the next cycle
// and keeps it high for INTR_CLOCK cycles. A load while the pulse is still
// running restarts the count, so overlapping events extend one pulse.
// Ports: clk, rst_n (async, active low), load (event strobe), irq_o.
module modbus_irq_stretch #(
    parameter int INTR_CLOCK = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic irq_o
);

    localparam int CW = $clog2(INTR_CLOCK + 1);

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_next_s;
    logic          irq_r;

    // Next count: reload on an event, otherwise run down to zero and stop.
    always_comb begin
        cnt_next_s = cnt_r;
        if (load) begin
            cnt_next_s = CW'(INTR_CLOCK);
        end else if (cnt_r != {CW{1'b0}}) begin
            cnt_next_s = cnt_r - CW'(1);
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Counter and registered pulse; the pulse mirrors the next count so it
    // stays high exactly INTR_CLOCK cycles after the last load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CW{1'b0}};
            irq_r <= 1'b0;
        end else begin
            cnt_r <= cnt_next_s;
            irq_r <= (cnt_next_s != {CW{1'b0}});
        end
    end

    assign irq_o = irq_r;

endmodule

// File: rtl/modbus_holding_reg_bank.sv
// Parametrised Modbus holding-register bank.
// Serves func 03 reads and func 06/16 writes arriving one word per strobe.
// Words of a write are staged in a shadow store and committed to the live
// registers in a single cycle once the whole transaction proved legal; any
// out-of-range or read-only word rejects the entire transaction.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   bus            request bus (slave side)
//   regs_o         live register contents, reg i at [16i+15:16i]
//   reg_update_o   sticky per-register written flags
//   update_clr     per-bit clear of reg_update_o (a same-cycle commit wins)
//   irq_o          stretched write-complete interrupt
module modbus_holding_reg_bank
    import modbus_pkg::*;
#(
    parameter int                       NUM_REGS   = 8,
    parameter logic [15:0]              BASE_ADDR  = 16'h0000,
    parameter logic [NUM_REGS-1:0]      RO_MASK    = {NUM_REGS{1'b0}},
    parameter logic [NUM_REGS*16-1:0]   RESET_VAL  = {NUM_REGS{16'h0}},
    parameter int                       INTR_CLOCK = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    modbus_holding_reg_bank_if.slave   bus,
    output logic [NUM_REGS*DATA_W-1:0] regs_o,
    output logic [NUM_REGS-1:0]        reg_update_o,
    input  logic [NUM_REGS-1:0]        update_clr,
    output logic                       irq_o
);

    wr_state_e         state_r;
    logic [DATA_W-1:0] shadow_r [NUM_REGS];
    logic [DATA_W-1:0] regs_r   [NUM_REGS];
    logic [NUM_REGS-1:0] pend_r;
    logic [NUM_REGS-1:0] update_r;

    logic [ADDR_W-1:0] wr_idx_s;
    logic [ADDR_W-1:0] rd_idx_s;
    logic [NUM_REGS-1:0] wr_sel_s;
    logic [NUM_REGS-1:0] rd_sel_s;
    logic              wr_legal_s;
    logic              rd_hit_s;
    logic [DATA_W-1:0] rd_word_s;
    logic              commit_s;

    logic              wr_done_r;
    logic              wr_status_r;
    logic              rd_vld_r;
    logic              rd_err_r;
    logic [DATA_W-1:0] rd_data_r;

    // Address decode: one-hot selects for both ports; an empty select means
    // out of range, so legality and read muxing need no variable indexing.
    always_comb begin
        wr_idx_s  = addr_offset(bus.wr_addr, BASE_ADDR);
        rd_idx_s  = addr_offset(bus.rd_addr, BASE_ADDR);
        wr_sel_s  = {NUM_REGS{1'b0}};
        rd_sel_s  = {NUM_REGS{1'b0}};
        rd_word_s = 16'h0000;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_sel_s[i] = (wr_idx_s == ADDR_W'(i));
            rd_sel_s[i] = (rd_idx_s == ADDR_W'(i));
            rd_word_s   = rd_word_s | (rd_sel_s[i] ? regs_r[i] : 16'h0000);
        end
        wr_legal_s = |(wr_sel_s & ~RO_MASK);
        rd_hit_s   = |rd_sel_s;
    end

    assign commit_s = (state_r == ST_COMMIT);

    // Write FSM with shadow store, pending mask and registered completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            pend_r      <= {NUM_REGS{1'b0}};
            wr_done_r   <= 1'b0;
            wr_status_r <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow_r[i] <= 16'h0000;
            end
        end else begin
            wr_done_r   <= 1'b0;
            wr_status_r <= 1'b0;
            case (state_r)
                ST_IDLE, ST_STAGE: begin
                    if (bus.wr_req && wr_legal_s) begin
                        // Repeated indices simply overwrite: last word wins.
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (wr_sel_s[i]) begin
                                shadow_r[i] <= bus.wr_data;
                            end
                        end
                        pend_r  <= pend_r | wr_sel_s;
                        state_r <= bus.wr_last ? ST_COMMIT : ST_STAGE;
                    end else if (bus.wr_req) begin
                        pend_r <= {NUM_REGS{1'b0}};
                        if (bus.wr_last) begin
                            wr_done_r   <= 1'b1;
                            wr_status_r <= 1'b1;
                            state_r     <= ST_IDLE;
                        end else begin
                            state_r <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Swallow the rest of a doomed transaction.
                    if (bus.wr_req && bus.wr_last) begin
                        wr_done_r   <= 1'b1;
                        wr_status_r <= 1'b1;
                        pend_r      <= {NUM_REGS{1'b0}};
                        state_r     <= ST_IDLE;
                    end
                end
                ST_COMMIT: begin
                    // Any word arriving here is a protocol violation; dropped.
                    wr_done_r   <= 1'b1;
                    wr_status_r <= 1'b0;
                    pend_r      <= {NUM_REGS{1'b0}};
                    state_r     <= ST_IDLE;
                end
                default: begin
                    pend_r  <= {NUM_REGS{1'b0}};
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Live registers and sticky update flags; a commit beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            update_r <= {NUM_REGS{1'b0}};
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= RESET_VAL[i*16 +: 16];
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (commit_s && pend_r[i]) begin
                    regs_r[i] <= shadow_r[i];
                end
            end
            update_r <= (update_r & ~update_clr) |
                        (commit_s ? pend_r : {NUM_REGS{1'b0}});
        end
    end

    // Read port: always sees committed registers, so a read in the commit
    // cycle returns the pre-commit value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_r  <= 1'b0;
            rd_err_r  <= 1'b0;
            rd_data_r <= 16'h0000;
        end else begin
            rd_vld_r <= bus.rd_req;
            rd_err_r <= bus.rd_req & ~rd_hit_s;
            if (bus.rd_req) begin
                rd_data_r <= rd_word_s;
            end
        end
    end

    modbus_irq_stretch #(
        .INTR_CLOCK (INTR_CLOCK)
    ) u_irq_stretch (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (commit_s),
        .irq_o (irq_o)
    );

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_flat
        assign regs_o[g*16 +: 16] = regs_r[g];
    end

    assign reg_update_o  = update_r;
    assign bus.wr_done   = wr_done_r;
    assign bus.wr_status = wr_status_r;
    assign bus.rd_vld    = rd_vld_r;
    assign bus.rd_err    = rd_err_r;
    assign bus.rd_data   = rd_data_r;

endmodule

// File: tb/tb_modbus_holding_reg_bank.sv
// Self-checking bench for modbus_holding_reg_bank. Transactions are modelled
// as whole units: a write commits iff every word is legal, staged values use
// last-wins per index, and the interrupt is the union of INTR_CLOCK-long
// windows opened by each commit.
module tb_modbus_holding_reg_bank;
    import modbus_pkg::*;

    localparam int              N    = 8;
    localparam int              IC   = 5;
    localparam logic [15:0]     BASE = 16'h0000;
    localparam logic [N-1:0]    RO   = 8'b0010_0000;
    localparam logic [N*16-1:0] RV   = {16'hF00F, 16'h0000, 16'h0000, 16'h0000,
                                        16'h0000, 16'h1234, 16'h0000, 16'h00A5};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N*16-1:0] regs_o;
    logic [N-1:0]    reg_update_o;
    logic [N-1:0]    update_clr;
    logic            irq_o;

    modbus_holding_reg_bank_if bus ();

    modbus_holding_reg_bank #(
        .NUM_REGS   (N),
        .BASE_ADDR  (BASE),
        .RO_MASK    (RO),
        .RESET_VAL  (RV),
        .INTR_CLOCK (IC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .regs_o       (regs_o),
        .reg_update_o (reg_update_o),
        .update_clr   (update_clr),
        .irq_o        (irq_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // reference model state
    logic [15:0] m_regs [N];
    logic [N-1:0] m_flags;
    int irq_starts[$];
    int cm_due = -1;
    logic [N-1:0] cm_mask;
    logic [15:0] cm_vals [N];
    int clr_due = -1;
    logic [N-1:0] clr_val;
    int done_due = -1;
    logic done_st;
    int rd_due = -1;
    logic [15:0] rd_exp;
    logic rd_err_exp;
    int fixed_rd = -1;
    logic [15:0] tx_addr[$];
    logic [15:0] tx_data[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    function automatic bit is_legal(input logic [15:0] a);
        logic [15:0] off;
        off = a - BASE;
        if (int'(off) >= N) return 1'b0;
        return !RO[int'(off)];
    endfunction

    function automatic bit exp_irq(input int c);
        foreach (irq_starts[k]) begin
            if (c >= irq_starts[k] && c < irq_starts[k] + IC) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_regs[i] = RV[i*16 +: 16];
        m_flags = '0;
        cm_due = -1; clr_due = -1; done_due = -1; rd_due = -1;
        irq_starts.delete();
    endtask

    // advance one clock, update the model, compare every observable output
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (clr_due == cyc) m_flags = m_flags & ~clr_val;
        if (cm_due == cyc) begin
            for (int i = 0; i < N; i++) if (cm_mask[i]) m_regs[i] = cm_vals[i];
            m_flags = m_flags | cm_mask;
            irq_starts.push_back(cyc);
        end
        check_eq("irq", irq_o, exp_irq(cyc));
        if (done_due == cyc) begin
            check_eq("wr_done", bus.wr_done, 1);
            check_eq("wr_status", bus.wr_status, done_st);
        end else begin
            check_eq("wr_done_idle", bus.wr_done, 0);
        end
        if (rd_due == cyc) begin
            check_eq("rd_vld", bus.rd_vld, 1);
            check_eq("rd_data", bus.rd_data, rd_exp);
            check_eq("rd_err", bus.rd_err, rd_err_exp);
        end else begin
            check_eq("rd_vld_idle", bus.rd_vld, 0);
        end
        for (int i = 0; i < N; i++) check_eq($sformatf("reg%0d", i), regs_o[i*16 +: 16], m_regs[i]);
        check_eq("flags", reg_update_o, m_flags);
        bus.wr_req = 1'b0;
        bus.wr_last = 1'b0;
        bus.rd_req = 1'b0;
        update_clr = '0;
    endtask

    task automatic issue_read(input logic [15:0] a);
        logic [15:0] off;
        off = a - BASE;
        bus.rd_req = 1'b1;
        bus.rd_addr = a;
        rd_due = cyc + 1;
        if (int'(off) < N) begin
            rd_exp = m_regs[int'(off)];
            rd_err_exp = 1'b0;
        end else begin
            rd_exp = 16'h0000;
            rd_err_exp = 1'b1;
        end
    endtask

    task automatic issue_clr(input logic [N-1:0] v);
        update_clr = v;
        clr_val = v;
        clr_due = cyc + 1;
    endtask

    task automatic side(input bit rnd);
        if (fixed_rd >= 0) issue_read(16'(fixed_rd));
        else if (rnd && ($urandom % 3 == 0)) issue_read(16'($urandom_range(0, 11)));
        if (rnd && ($urandom % 4 == 0)) issue_clr(N'($urandom));
    endtask

    // drive tx_addr/tx_data as one transaction and predict its outcome
    task automatic write_txn(input int max_gap, input bit rnd, input logic [N-1:0] clr_commit);
        bit ok;
        bit last;
        logic [15:0] stage [N];
        logic [N-1:0] mask;
        logic [15:0] off;
        ok = 1'b1;
        mask = '0;
        for (int i = 0; i < N; i++) stage[i] = 16'h0000;
        for (int k = 0; k < tx_addr.size(); k++) begin
            last = (k == tx_addr.size() - 1);
            bus.wr_req = 1'b1;
            bus.wr_addr = tx_addr[k];
            bus.wr_data = tx_data[k];
            bus.wr_last = last;
            if (ok) begin
                if (is_legal(tx_addr[k])) begin
                    off = tx_addr[k] - BASE;
                    stage[int'(off)] = tx_data[k];
                    mask[int'(off)] = 1'b1;
                end else begin
                    ok = 1'b0;
                end
            end
            side(rnd);
            if (last) begin
                if (ok) begin
                    cm_due = cyc + 2; cm_mask = mask; cm_vals = stage;
                    done_due = cyc + 2; done_st = 1'b0;
                end else begin
                    done_due = cyc + 1; done_st = 1'b1;
                end
            end
            tick();
            if (!last) begin
                repeat ($urandom_range(0, max_gap)) begin
                    side(rnd);
                    tick();
                end
            end
        end
        if (ok) begin
            side(rnd);
            if (clr_commit != '0) issue_clr(clr_commit);
            tick();
        end
    endtask

    task automatic idle(input int n, input bit rnd);
        repeat (n) begin
            side(rnd);
            tick();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_last = 1'b0;
        bus.rd_req = 1'b0; bus.rd_addr = '0;
        update_clr = '0;
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // reset value readback
        issue_read(16'd2);
        tick();
        idle(1, 1'b0);

        // single-word write with full interrupt pulse
        tx_addr = {16'd3}; tx_data = {16'hBEEF};
        write_txn(0, 1'b0, '0);
        idle(IC + 2, 1'b0);

        // staged burst, reading addr 1 throughout
        fixed_rd = 1;
        tx_addr = {16'd0, 16'd1, 16'd2}; tx_data = {16'h0001, 16'h0002, 16'h0003};
        write_txn(1, 1'b0, '0);
        fixed_rd = -1;
        idle(IC + 2, 1'b0);

        // rejections: out of range, read-only single, read-only inside burst
        tx_addr = {16'd4, 16'd9}; tx_data = {16'h4444, 16'h9999};
        write_txn(1, 1'b0, '0);
        tx_addr = {16'd5}; tx_data = {16'h5555};
        write_txn(0, 1'b0, '0);
        tx_addr = {16'd4, 16'd5, 16'd6}; tx_data = {16'h4444, 16'h5555, 16'h6666};
        write_txn(1, 1'b0, '0);
        tx_addr = {16'hFFFF}; tx_data = {16'h7777};
        write_txn(0, 1'b0, '0);
        idle(2, 1'b0);

        // second commit three cycles into the pulse extends it
        tx_addr = {16'd1}; tx_data = {16'hAAAA};
        write_txn(0, 1'b0, '0);
        idle(1, 1'b0);
        tx_addr = {16'd2}; tx_data = {16'hBBBB};
        write_txn(0, 1'b0, '0);
        idle(IC + 3, 1'b0);

        // clear racing a commit to the same register, then a plain clear
        tx_addr = {16'd3}; tx_data = {16'h1357};
        write_txn(0, 1'b0, 8'h08);
        issue_clr(8'h08);
        tick();
        idle(IC + 2, 1'b0);

        // reset in the middle of a burst
        bus.wr_req = 1'b1; bus.wr_addr = 16'd0; bus.wr_data = 16'h5A5A; bus.wr_last = 1'b0;
        tick();
        bus.wr_req = 1'b1; bus.wr_addr = 16'd1; bus.wr_data = 16'hA5A5; bus.wr_last = 1'b0;
        tick();
        rst_n = 1'b0;
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tx_addr = {16'd6}; tx_data = {16'h6666};
        write_txn(0, 1'b0, '0);
        idle(IC + 2, 1'b0);

        // randomized transactions with background reads and clears
        for (int t = 0; t < 60; t++) begin
            int len;
            len = $urandom_range(1, 4);
            tx_addr.delete();
            tx_data.delete();
            for (int k = 0; k < len; k++) begin
                if ($urandom % 6 == 0) tx_addr.push_back(16'($urandom_range(8, 11)));
                else tx_addr.push_back(16'($urandom_range(0, 7)));
                tx_data.push_back(16'($urandom));
            end
            write_txn(2, 1'b1, '0);
            idle($urandom_range(0, 3), 1'b1);
        end
        idle(IC + 2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/modbus_holding_reg_bank.md
Name: modbus_holding_reg_bank

Overview:
Parametrised holding-register bank replacing the single hard-wired 03/01 register in the RTU slave top. It serves func 03 reads and func 06/16 writes from the function handler over a word-serial request interface. Multi-word writes are staged and committed atomically. It produces per-register update flags and a stretched interrupt pulse after each committed write.

Parameters:
NUM_REGS, 8, number of 16-bit holding registers (1..32)
BASE_ADDR, 16'h0000, Modbus address of register 0
RO_MASK, {NUM_REGS{1'b0}}, bit i set = register i is read-only (write returns exception)
RESET_VAL, {NUM_REGS{16'h0}}, flat NUM_REGS*16 reset values, reg i at [16i+15:16i]
INTR_CLOCK, 5, interrupt pulse length in clk cycles (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous reset, active low
wr_req  in  1  one-cycle strobe, one word per strobe
wr_addr  in  16  Modbus register address of this word
wr_data  in  16  word value
wr_last  in  1  qualifies wr_req: final word of transaction (func 06 = single word with wr_last=1)
wr_done  out  1  one-cycle pulse, transaction finished
wr_status  out  1  valid with wr_done: 0 committed, 1 rejected (exception 02)
rd_req  in  1  one-cycle read strobe
rd_addr  in  16  Modbus register address
rd_data  out  16  read data, valid with rd_vld
rd_vld  out  1  one-cycle pulse, 1 cycle after rd_req
rd_err  out  1  valid with rd_vld: address out of range
regs_o  out  NUM_REGS*16  live register contents, flat
reg_update_o  out  NUM_REGS  sticky per-register "written" flags
update_clr  in  NUM_REGS  per-bit clear of reg_update_o
irq_o  out  1  write-complete interrupt, INTR_CLOCK cycles high

Behaviour:
- Reset: regs = RESET_VAL; shadow, pend_mask, reg_update_o = 0; wr_done, wr_status, rd_vld, rd_err, irq_o = 0; rd_data = 0; FSM = IDLE; irq counter = 0.
- Index = wr_addr - BASE_ADDR (16-bit wrap). Illegal if index >= NUM_REGS, or RO_MASK[index] = 1.
- FSM states: IDLE, STAGE, DRAIN, COMMIT.
- IDLE: wr_req, legal -> shadow[idx] <= data, pend_mask[idx] <= 1; wr_last ? COMMIT : STAGE. wr_req, illegal -> wr_last ? (wr_done=1, wr_status=1 next cycle, stay IDLE) : DRAIN.
- STAGE: legal word -> stage it; a repeated index overwrites shadow (last wins). Illegal word -> clear pend_mask, go DRAIN (or reject immediately if wr_last). wr_last on a legal word -> COMMIT.
- DRAIN: ignore words until wr_last -> wr_done=1, wr_status=1, pend_mask=0, IDLE. No register or flag changes.
- COMMIT (1 cycle): every i with pend_mask[i] -> regs[i] <= shadow[i], reg_update_o[i] <= 1; pend_mask <= 0. wr_done=1, wr_status=0 in the same cycle. Latency from last wr_req to wr_done is 2 cycles on commit and 1 cycle on immediate reject. A wr_req arriving during COMMIT is a protocol violation and is dropped.
- Reads: rd_data/rd_err registered 1 cycle after rd_req. Reads return committed regs, never shadow. Out-of-range reads give rd_data=0, rd_err=1. RO registers are readable.
- Read in the COMMIT cycle returns the pre-commit value.
- update_clr[i] clears reg_update_o[i]. A COMMIT set on the same bit in the same cycle wins (flag stays 1).
- irq: a COMMIT cycle loads counter = INTR_CLOCK and sets irq_o on the next cycle. irq_o holds while counter != 0, decrementing each cycle. A new commit while irq_o is high reloads the counter, so the pulse is extended, not doubled. Rejected transactions never raise irq_o.
- Reset asserted mid-transaction discards staged data; regs return to RESET_VAL.

Decomposition:
- Shared package modbus_pkg: exception code constants (EXC_ILLEGAL_ADDR = 8'h02), Modbus address width (16), data width (16).
- FSM, shadow store and register array stay in this module.
- One sub-module is natural: modbus_irq_stretch (reloadable down-counter pulse stretcher, parameter INTR_CLOCK), reusable by the top for other interrupts.

Test Plan:
- Reset with RESET_VAL reg2 = 16'h1234; read addr 2 -> rd_vld after 1 cycle, rd_data = 16'h1234, rd_err = 0; irq_o = 0.
- Func 06 write addr 3 = 16'hBEEF (wr_last=1) -> wr_done 2 cycles later, status 0; regs_o[63:48] = 16'hBEEF; reg_update_o[3] = 1; irq_o high for exactly 5 cycles.
- Burst addrs 0,1,2 = 16'h0001/0002/0003 -> regs unchanged until COMMIT, then all three update in one cycle; a read of addr 1 during STAGE returns the old value.
- Burst addrs 4,9 (9 >= NUM_REGS) -> wr_done with status 1; reg 4 unchanged; no update flags; irq_o stays 0. Repeat with RO_MASK[5]=1 writing addr 5 -> same rejection.
- Second commit 3 cycles into the irq pulse -> irq_o stays high continuously for 3 + 5 cycles.
- update_clr[3] in the same cycle as a commit to reg 3 -> flag remains 1. Then assert rst_n low mid-burst -> all regs = RESET_VAL, FSM IDLE, no wr_done.
